// File: rtl/bcp_pkg.sv
// Shared types and helpers for the BCP clause evaluator.
//   status_e  : clause classification reported on out_status.
//   lit_true  : a literal is true when its variable is assigned and the
//               assigned value matches the literal polarity.
package bcp_pkg;

  typedef enum logic [1:0] {
    ST_SAT      = 2'd0,
    ST_UNIT     = 2'd1,
    ST_CONFLICT = 2'd2,
    ST_UNRES    = 2'd3
  } status_e;

  // Saturated free-literal count: 0, 1 or 2 (meaning "two or more").
  localparam int FREE_CNT_W = 2;

  function automatic logic lit_true(input logic val, input logic pol, input logic asgn);
    return asgn & (val == pol);
  endfunction

endpackage

// File: rtl/bcp_lit_scan.sv
// Combinational literal scanner.
// Ports:
//   live           in  per-literal live mask (literal index < clause length)
//   val/pol/asgn   in  per-literal value, polarity, assigned flag
//   true_vec       out live & literal true
//   free_vec       out live & variable unassigned
//   any_true       out at least one live literal is true
//   free_cnt_sat   out number of free live literals, saturated at 2
//   first_free_idx out lowest index of a free live literal (0 if none)
module bcp_lit_scan
  import bcp_pkg::*;
#(
  parameter int MAX_LITS = 4,
  parameter int IDX_W    = $clog2(MAX_LITS)
) (
  input  logic [MAX_LITS-1:0]   live,
  input  logic [MAX_LITS-1:0]   val,
  input  logic [MAX_LITS-1:0]   pol,
  input  logic [MAX_LITS-1:0]   asgn,
  output logic [MAX_LITS-1:0]   true_vec,
  output logic [MAX_LITS-1:0]   free_vec,
  output logic                  any_true,
  output logic [FREE_CNT_W-1:0] free_cnt_sat,
  output logic [IDX_W-1:0]      first_free_idx
);

  int free_cnt;

  always_comb begin
    true_vec       = '0;
    free_vec       = '0;
    free_cnt       = 0;
    first_free_idx = '0;
    // Walk from the top index down so the lowest free index is the last write.
    for (int i = MAX_LITS - 1; i >= 0; i--) begin
      true_vec[i] = live[i] & lit_true(val[i], pol[i], asgn[i]);
      free_vec[i] = live[i] & ~asgn[i];
      if (free_vec[i]) begin
        free_cnt       = free_cnt + 1;
        first_free_idx = IDX_W'(i);
      end
    end
    any_true     = |true_vec;
    free_cnt_sat = (free_cnt >= 2) ? FREE_CNT_W'(2) : FREE_CNT_W'(free_cnt);
  end

endmodule

// File: rtl/bcp_clause_eval.sv
// Two-stage pipelined clause evaluator for the BCP engine.
// One clause enters per accepted beat; the result leaves two cycles later
// classified as SAT, UNIT, CONFLICT or UNRESOLVED, with the implied literal
// index/value for UNIT.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   in_valid/in_ready                input handshake
//   in_id, in_len, in_val,
//   in_pol, in_asgn                  clause payload
//   out_valid/out_ready              output handshake
//   out_id, out_status, out_idx,
//   out_imp_val                      result payload
//   clr_stats                        clear counters and conflict_seen
//   conflict_seen                    sticky CONFLICT-emitted flag
//   unit_cnt, conflict_cnt           saturating event counters
module bcp_clause_eval
  import bcp_pkg::*;
#(
  parameter int MAX_LITS         = 4,
  parameter int ID_W             = 16,
  parameter int CNT_W            = 16,
  parameter int HALT_ON_CONFLICT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ID_W-1:0]               in_id,
  input  logic [$clog2(MAX_LITS+1)-1:0] in_len,
  input  logic [MAX_LITS-1:0]           in_val,
  input  logic [MAX_LITS-1:0]           in_pol,
  input  logic [MAX_LITS-1:0]           in_asgn,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ID_W-1:0]               out_id,
  output status_e                       out_status,
  output logic [$clog2(MAX_LITS)-1:0]   out_idx,
  output logic                          out_imp_val,
  input  logic                          clr_stats,
  output logic                          conflict_seen,
  output logic [CNT_W-1:0]              unit_cnt,
  output logic [CNT_W-1:0]              conflict_cnt
);

  localparam int LEN_W = $clog2(MAX_LITS + 1);
  localparam int IDX_W = $clog2(MAX_LITS);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_LITS);

  // Handshake: a transfer happens on a side when valid & ready are both high
  // at a rising edge. Each stage loads when it is empty or its downstream
  // consumes in the same cycle, so in_ready depends combinationally on
  // out_ready. Output payload is held stable while out_valid & !out_ready.

  // ---------------- Stage registers ----------------
  logic                  s1_v_q,         s1_v_d;
  logic [ID_W-1:0]       s1_id_q,        s1_id_d;
  logic [MAX_LITS-1:0]   s1_true_q,      s1_true_d;
  logic [MAX_LITS-1:0]   s1_free_q,      s1_free_d;
  logic [MAX_LITS-1:0]   s1_pol_q,       s1_pol_d;
  logic [FREE_CNT_W-1:0] s1_free_cnt_q,  s1_free_cnt_d;
  logic [IDX_W-1:0]      s1_first_idx_q, s1_first_idx_d;

  logic                  s2_v_q,         s2_v_d;
  logic [ID_W-1:0]       s2_id_q,        s2_id_d;
  status_e               s2_status_q,    s2_status_d;
  logic [IDX_W-1:0]      s2_idx_q,       s2_idx_d;
  logic                  s2_imp_q,       s2_imp_d;

  logic [CNT_W-1:0]      unit_cnt_q,     unit_cnt_d;
  logic [CNT_W-1:0]      conflict_cnt_q, conflict_cnt_d;
  logic                  conflict_seen_q, conflict_seen_d;

  // ---------------- Flow control ----------------
  logic halt;
  logic s2_load;
  logic s1_load;
  logic in_accept;
  logic out_hs;

  assign halt      = (HALT_ON_CONFLICT != 0) && conflict_seen_q;
  assign s2_load   = ~s2_v_q | out_ready;
  assign s1_load   = ~s1_v_q | s2_load;
  assign in_ready  = s1_load & ~halt;
  assign in_accept = in_valid & in_ready;
  assign out_hs    = s2_v_q & out_ready;

  // ---------------- Stage 1: literal scan ----------------
  logic [LEN_W-1:0]      len_clamped;
  logic [MAX_LITS-1:0]   live_mask;
  logic [MAX_LITS-1:0]   scan_true;
  logic [MAX_LITS-1:0]   scan_free;
  logic                  scan_any_true;
  logic [FREE_CNT_W-1:0] scan_free_cnt;
  logic [IDX_W-1:0]      scan_first_idx;

  always_comb begin
    len_clamped = (in_len > MAX_LEN) ? MAX_LEN : in_len;
    live_mask   = '0;
    for (int i = 0; i < MAX_LITS; i++) begin
      live_mask[i] = (LEN_W'(i) < len_clamped);
    end
  end

  bcp_lit_scan #(
    .MAX_LITS (MAX_LITS),
    .IDX_W    (IDX_W)
  ) u_scan (
    .live           (live_mask),
    .val            (in_val),
    .pol            (in_pol),
    .asgn           (in_asgn),
    .true_vec       (scan_true),
    .free_vec       (scan_free),
    .any_true       (scan_any_true),
    .free_cnt_sat   (scan_free_cnt),
    .first_free_idx (scan_first_idx)
  );

  always_comb begin
    s1_v_d         = s1_v_q;
    s1_id_d        = s1_id_q;
    s1_true_d      = s1_true_q;
    s1_free_d      = s1_free_q;
    s1_pol_d       = s1_pol_q;
    s1_free_cnt_d  = s1_free_cnt_q;
    s1_first_idx_d = s1_first_idx_q;
    if (s1_load) begin
      s1_v_d = in_accept;
      if (in_accept) begin
        s1_id_d        = in_id;
        s1_true_d      = scan_true;
        s1_free_d      = scan_free;
        s1_pol_d       = in_pol;
        s1_free_cnt_d  = scan_free_cnt;
        s1_first_idx_d = scan_first_idx;
      end
    end
  end

  // scan_any_true is recomputed in stage 2 from the registered flags.
  logic unused_any_true;
  assign unused_any_true = scan_any_true;

  // ---------------- Stage 2: classification ----------------
  status_e          cls_status;
  logic [IDX_W-1:0] cls_idx;
  logic             cls_imp;

  always_comb begin
    cls_status = ST_UNRES;
    cls_idx    = '0;
    cls_imp    = 1'b0;
    if (|s1_true_q) begin
      cls_status = ST_SAT;
    end else begin
      case (s1_free_cnt_q)
        FREE_CNT_W'(0): cls_status = ST_CONFLICT;
        FREE_CNT_W'(1): begin
          cls_status = ST_UNIT;
          cls_idx    = s1_first_idx_q;
          // Exactly one free bit is set, so this selects its polarity.
          cls_imp    = |(s1_free_q & s1_pol_q);
        end
        default:        cls_status = ST_UNRES;
      endcase
    end
  end

  always_comb begin
    s2_v_d      = s2_v_q;
    s2_id_d     = s2_id_q;
    s2_status_d = s2_status_q;
    s2_idx_d    = s2_idx_q;
    s2_imp_d    = s2_imp_q;
    if (s2_load) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_id_d     = s1_id_q;
        s2_status_d = cls_status;
        s2_idx_d    = cls_idx;
        s2_imp_d    = cls_imp;
      end
    end
  end

  // ---------------- Statistics ----------------
  logic unit_hs;
  logic conf_hs;

  assign unit_hs = out_hs && (s2_status_q == ST_UNIT);
  assign conf_hs = out_hs && (s2_status_q == ST_CONFLICT);

  // A clear that coincides with a counted event leaves that event recorded.
  always_comb begin
    unit_cnt_d      = unit_cnt_q;
    conflict_cnt_d  = conflict_cnt_q;
    conflict_seen_d = conflict_seen_q | conf_hs;
    if (clr_stats) begin
      unit_cnt_d      = unit_hs ? CNT_W'(1) : '0;
      conflict_cnt_d  = conf_hs ? CNT_W'(1) : '0;
      conflict_seen_d = conf_hs;
    end else begin
      if (unit_hs && (unit_cnt_q != '1)) begin
        unit_cnt_d = unit_cnt_q + CNT_W'(1);
      end
      if (conf_hs && (conflict_cnt_q != '1)) begin
        conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
      end
    end
  end

  // ---------------- Registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q          <= 1'b0;
      s1_id_q         <= '0;
      s1_true_q       <= '0;
      s1_free_q       <= '0;
      s1_pol_q        <= '0;
      s1_free_cnt_q   <= '0;
      s1_first_idx_q  <= '0;
      s2_v_q          <= 1'b0;
      s2_id_q         <= '0;
      s2_status_q     <= ST_SAT;
      s2_idx_q        <= '0;
      s2_imp_q        <= 1'b0;
      unit_cnt_q      <= '0;
      conflict_cnt_q  <= '0;
      conflict_seen_q <= 1'b0;
    end else begin
      s1_v_q          <= s1_v_d;
      s1_id_q         <= s1_id_d;
      s1_true_q       <= s1_true_d;
      s1_free_q       <= s1_free_d;
      s1_pol_q        <= s1_pol_d;
      s1_free_cnt_q   <= s1_free_cnt_d;
      s1_first_idx_q  <= s1_first_idx_d;
      s2_v_q          <= s2_v_d;
      s2_id_q         <= s2_id_d;
      s2_status_q     <= s2_status_d;
      s2_idx_q        <= s2_idx_d;
      s2_imp_q        <= s2_imp_d;
      unit_cnt_q      <= unit_cnt_d;
      conflict_cnt_q  <= conflict_cnt_d;
      conflict_seen_q <= conflict_seen_d;
    end
  end

  assign out_valid     = s2_v_q;
  assign out_id        = s2_id_q;
  assign out_status    = s2_status_q;
  assign out_idx       = s2_idx_q;
  assign out_imp_val   = s2_imp_q;
  assign unit_cnt      = unit_cnt_q;
  assign conflict_cnt  = conflict_cnt_q;
  assign conflict_seen = conflict_seen_q;

endmodule

// File: tb/tb_bcp_clause_eval.sv
// Scoreboard bench for bcp_clause_eval (MAX_LITS=4, CNT_W=4, halt enabled).
module tb_bcp_clause_eval;

  localparam int MAX_LITS = 4;
  localparam int ID_W     = 16;
  localparam int CNT_W    = 4;
  localparam int LEN_W    = 3;
  localparam int IDX_W    = 2;
  localparam int EXP_W    = ID_W + 2 + IDX_W + 1;

  // ---------------- Clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic                clr_stats;
  logic                in_valid;
  logic                in_ready;
  logic [ID_W-1:0]     in_id;
  logic [LEN_W-1:0]    in_len;
  logic [MAX_LITS-1:0] in_val;
  logic [MAX_LITS-1:0] in_pol;
  logic [MAX_LITS-1:0] in_asgn;
  logic                out_valid;
  logic                out_ready;
  logic [ID_W-1:0]     out_id;
  logic [1:0]          out_status;
  logic [IDX_W-1:0]    out_idx;
  logic                out_imp_val;
  logic                conflict_seen;
  logic [CNT_W-1:0]    unit_cnt;
  logic [CNT_W-1:0]    conflict_cnt;

  bcp_clause_eval #(
    .MAX_LITS         (MAX_LITS),
    .ID_W             (ID_W),
    .CNT_W            (CNT_W),
    .HALT_ON_CONFLICT (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_id         (in_id),
    .in_len        (in_len),
    .in_val        (in_val),
    .in_pol        (in_pol),
    .in_asgn       (in_asgn),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_id        (out_id),
    .out_status    (out_status),
    .out_idx       (out_idx),
    .out_imp_val   (out_imp_val),
    .clr_stats     (clr_stats),
    .conflict_seen (conflict_seen),
    .unit_cnt      (unit_cnt),
    .conflict_cnt  (conflict_cnt)
  );

  // ---------------- Scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int m_unit = 0;
  int m_conf = 0;
  bit m_seen = 0;
  int rdy_mode = 0;   // 0 always, 1 toggle, 2 random, 3 manual, 4 never
  logic [ID_W-1:0] id_ctr = 16'h0100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: classify from the clause rules directly.
  function automatic logic [EXP_W-1:0] ref_model(input logic [ID_W-1:0] id, input int len,
                                                 input logic [3:0] val, input logic [3:0] pol,
                                                 input logic [3:0] asgn);
    int n;
    int nfree;
    int first;
    bit sat;
    logic [1:0] st;
    logic [1:0] idx;
    logic imp;
    n = (len > MAX_LITS) ? MAX_LITS : len;
    nfree = 0; first = 0; sat = 0; idx = 0; imp = 0;
    for (int i = 0; i < n; i++) begin
      if (asgn[i] && (val[i] == pol[i])) sat = 1;
      if (!asgn[i]) begin
        if (nfree == 0) first = i;
        nfree++;
      end
    end
    if (sat) st = 2'd0;
    else if (nfree == 0) st = 2'd2;
    else if (nfree == 1) begin
      st = 2'd1; idx = first[1:0]; imp = pol[first];
    end else st = 2'd3;
    return {id, st, idx, imp};
  endfunction

  // ---------------- Monitor ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    bit uh, ch;
    uh = 0; ch = 0;
    if (!rst_n) begin
      exp_q.delete();
      m_unit = 0; m_conf = 0; m_seen = 0;
    end else begin
      chk("unit_cnt", 32'(unit_cnt), 32'(m_unit));
      chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
      chk("conflict_seen", 32'(conflict_seen), 32'(m_seen));
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out: got id %0h with empty expected queue", out_id);
        end else begin
          e = exp_q[0];
          if ({out_id, out_status, out_idx, out_imp_val} !== e) begin
            bad++;
            $display("FAIL out_data: got id=%0h st=%0d idx=%0d imp=%0b want id=%0h st=%0d idx=%0d imp=%0b",
                     out_id, out_status, out_idx, out_imp_val,
                     e[EXP_W-1 -: ID_W], e[4:3], e[2:1], e[0]);
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            uh = (e[4:3] == 2'd1);
            ch = (e[4:3] == 2'd2);
          end
        end
      end
      if (clr_stats) begin
        m_unit = uh ? 1 : 0;
        m_conf = ch ? 1 : 0;
        m_seen = ch;
      end else begin
        if (uh && m_unit < 15) m_unit++;
        if (ch && m_conf < 15) m_conf++;
        if (ch) m_seen = 1;
      end
    end
  end

  // ---------------- out_ready driver ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        2: out_ready = ($urandom_range(0, 3) != 0);
        4: out_ready = 1'b0;
        default: ;
      endcase
    end
  end

  // ---------------- Driver tasks (enter/leave at posedge+1) ----------------
  task automatic pulse_clr();
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
  endtask

  task automatic send(input logic [2:0] len, input logic [3:0] val,
                      input logic [3:0] pol, input logic [3:0] asgn);
    int n;
    bit ok;
    in_id = id_ctr; in_len = len; in_val = val; in_pol = pol; in_asgn = asgn;
    in_valid = 1'b1;
    n = 0; ok = 0;
    while (!ok && n < 300) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else begin
        n++;
        if (conflict_seen) begin
          @(posedge clk); #1;
          pulse_clr();
        end
      end
    end
    if (!ok) begin
      chk("send_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
    end else begin
      exp_q.push_back(ref_model(id_ctr, int'(len), val, pol, asgn));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    id_ctr++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk); n++;
    end
    if (n >= 500) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  // Called right after the accepting edge with an empty pipeline and ready=1.
  task automatic lat_check(input string name);
    @(negedge clk);
    chk({name, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({name, "_lat2"}, 32'(out_valid), 32'd1);
    @(posedge clk); #1;
  endtask

  // ---------------- Watchdog ----------------
  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- Main sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0; clr_stats = 1'b0; in_valid = 1'b0;
    in_id = '0; in_len = '0; in_val = '0; in_pol = '0; in_asgn = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_id", 32'(out_id), 32'd0);
    @(posedge clk); #1;

    // Single UNIT on the last literal, checked for 2-cycle latency.
    send(3'd4, 4'b0000, 4'b1111, 4'b0111);
    lat_check("t1");
    drain();
    chk("t1_unit_cnt", 32'(unit_cnt), 32'd1);

    // CONFLICT then halt until clear.
    send(3'd3, 4'b0010, 4'b0101, 4'b0111);
    drain();
    chk("t2_seen", 32'(conflict_seen), 32'd1);
    chk("t2_conf_cnt", 32'(conflict_cnt), 32'd1);
    repeat (2) @(negedge clk);
    chk("t2_halted", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clr_stats = 1'b1;
    @(negedge clk);
    chk("t2_clr_cycle_blocked", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clr_stats = 1'b0;
    @(negedge clk);
    chk("t2_ready_after_clr", 32'(in_ready), 32'd1);
    chk("t2_conf_cnt_clr", 32'(conflict_cnt), 32'd0);
    @(posedge clk); #1;

    // Dead literals ignored; empty clause conflicts.
    send(3'd2, 4'b0000, 4'b0101, 4'b0001);
    send(3'd0, 4'b1111, 4'b1111, 4'b1111);
    send(3'd7, 4'b0000, 4'b1000, 4'b0111);   // length clamps to 4
    drain();

    // Back-to-back with toggling ready.
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) begin
      send(3'($urandom_range(1, 4)), 4'($urandom), 4'($urandom), 4'($urandom));
    end
    drain();

    // Reset with both stages occupied.
    rdy_mode = 4;
    @(posedge clk); #1;
    send(3'd4, 4'b0000, 4'b1111, 4'b0111);
    send(3'd2, 4'b0000, 4'b0101, 4'b0001);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdy_mode = 0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_unit_cnt", 32'(unit_cnt), 32'd0);
    chk("t5_conf_cnt", 32'(conflict_cnt), 32'd0);
    @(posedge clk); #1;
    send(3'd3, 4'b0001, 4'b1111, 4'b0110);
    lat_check("t5");
    drain();

    // Randomised traffic with random backpressure and idle gaps.
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end
    end
    rdy_mode = 0;
    drain();

    // Saturation and clear coinciding with a UNIT handshake.
    for (int i = 0; i < 20; i++) begin
      send(3'd2, 4'b0000, 4'b0011, 4'b0001);
    end
    drain();
    chk("t6_sat", 32'(unit_cnt), 32'd15);
    rdy_mode = 3;
    out_ready = 1'b0;
    send(3'd2, 4'b0000, 4'b0011, 4'b0001);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk); n++;
    end
    chk("t6_wait_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    chk("t6_clr_with_unit", 32'(unit_cnt), 32'd1);
    @(posedge clk); #1;
    drain();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
